mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port 16-bit main memory between two requesters: instruction fetch (read-only) and the execute stage's load/store port (read/write).
- Sits between the fetch/exec pipeline stages and main memory.
- Sequences one memory access at a time and returns the read data with a one-cycle ack.
- Drives per-requester stall signals so the pipeline holds while waiting.

Parameters:
AW, 16, address width
DW, 16, data width
MEM_LAT, 1, cycles from mem_en to valid mem_rdata (legal range 1..7)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch read request, held until if_ack
if_adr  input  AW  fetch address
if_ack  output  1  one-cycle pulse: fetch access complete, if_rdata valid
if_rdata  output  DW  fetched word (registered, holds until next fetch ack)
if_stall  output  1  if_req & ~if_ack
d_req  input  1  data request from exec stage, held until d_ack
d_we  input  1  1 = store, 0 = load (sampled with d_req)
d_adr  input  AW  load/store address (exec ALU result)
d_wdat  input  DW  store data (exec rd1)
d_ack  output  1  one-cycle pulse: data access complete
d_rdata  output  DW  loaded word (registered, holds until next load ack)
d_stall  output  1  d_req & ~d_ack
mem_en  output  1  one-cycle memory access strobe
mem_we  output  1  write enable, valid with mem_en
mem_adr  output  AW  memory address (registered)
mem_wdat  output  DW  memory write data (registered)
mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset: all outputs 0, state IDLE, last_data flag 0, latency counter 0.
- Reset mid-operation behaves the same. No ack is issued for the in-flight access. A write already strobed is not undone.
- States and transitions:
  - IDLE: sample requests.
    - Only one pending: grant it.
    - Both pending: grant data unless last_data=1, in which case grant fetch. This alternates under contention, so neither requester starves.
    - On grant: latch adr, we (0 for fetch), wdat and the grant source into registers, then go to ISSUE.
    - No request: stay in IDLE.
  - ISSUE: mem_en=1 for exactly this cycle with the latched mem_we/mem_adr/mem_wdat.
    - Write: go to ACK.
    - Read: load counter with MEM_LAT-1 and go to WAIT.
  - WAIT: decrement the counter each cycle. At counter 0, capture mem_rdata into if_rdata or d_rdata (per source), then go to ACK.
  - ACK: pulse if_ack or d_ack. Update last_data (1 if data was granted, else 0). Go to IDLE.
- Latency, with the request first seen in IDLE at cycle T:
  - mem_en at T+1.
  - Read ack at T+2+MEM_LAT.
  - Write ack at T+2.
- Handshake rules:
  - Requester holds req/adr/we/wdat stable until it sees ack.
  - Requester may drop req, or present a new request, in the cycle after ack.
  - The ACK cycle never re-samples requests, so a held req is never double-granted.
- Address/data changes while a request is pending but before grant are legal. The values latched at grant are used.
- Stalls are combinational; the pipeline freezes while stall=1.
- Data registers keep their last value on acks of the other source and on write acks.
- No width conversion: addresses and data pass straight through; the arbiter does no address arithmetic.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, ACK}.
  - grant-source enum {SRC_IF, SRC_D}.
  - Constant LAT_W = 3 (counter width).
- No sub-module is natural. The FSM, counter and registers stay inline in mem_arbiter.
- Bench uses a behavioural memory model with MEM_LAT read delay.

Test Plan:
- Fetch only, MEM_LAT=1, if_adr=16'h0010, memory word 16'hA5A5 -> mem_en at T+1 with mem_we=0, adr 0010; if_ack and if_rdata=A5A5 at T+3; if_stall high T..T+2.
- Store only, d_we=1, d_adr=16'h0100, d_wdat=16'h1234 -> mem_en and mem_we at T+1 with wdat 1234; d_ack at T+2; a subsequent load from 0100 returns 1234.
- if_req and d_req both asserted and held through two grants -> first grant data (last_data=0), second grant fetch; both acks arrive exactly once, in that order.
- Continuous contention over 6 accesses -> grants alternate D,F,D,F,D,F; no requester is granted twice in a row.
- MEM_LAT=3 load, memory word 16'h00FF -> d_ack and d_rdata=00FF at T+5; mem_en high only at T+1.
- Reset asserted in WAIT -> next cycle state IDLE, all outputs 0, no ack. A request still held after reset is re-granted from IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch / load-store memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  typedef enum logic {SRC_IF, SRC_D} src_t;

  localparam int LAT_W = 3;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port main memory between instruction fetch and the
// execute-stage load/store port, one access at a time with a one-cycle ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_adr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wdat,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdat,
  input  logic [DW-1:0] mem_rdata
);

  state_t             state, state_nx;
  src_t               src;
  logic               last_data;
  logic [LAT_W-1:0]   lat_cnt;
  logic               grant;
  logic               grant_d;

  // Under contention data wins unless it had the previous grant.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_d  = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!if_req || !last_data)) begin
          grant    = 1'b1;
          grant_d  = 1'b1;
          state_nx = ISSUE;
        end else if (if_req) begin
          grant    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE:   state_nx = mem_we ? ACK : WAIT;
      WAIT:    if (lat_cnt == '0) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_en   = (state == ISSUE);
  assign if_ack   = (state == ACK) && (src == SRC_IF);
  assign d_ack    = (state == ACK) && (src == SRC_D);
  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src       <= SRC_IF;
      last_data <= 1'b0;
      lat_cnt   <= '0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdat  <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        src      <= grant_d ? SRC_D : SRC_IF;
        mem_we   <= grant_d & d_we;
        mem_adr  <= grant_d ? d_adr : if_adr;
        mem_wdat <= grant_d ? d_wdat : '0;
      end
      if (state == ISSUE && !mem_we) begin
        lat_cnt <= LAT_W'(MEM_LAT - 1);
      end else if (state == WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      // Read data is captured on the last WAIT cycle so it is stable during ACK.
      if (state == WAIT && lat_cnt == '0) begin
        if (src == SRC_D) d_rdata  <= mem_rdata;
        else              if_rdata <= mem_rdata;
      end
      if (state == ACK) last_data <= (src == SRC_D);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 1 and 3), each with its own
// behavioural memory, directed scenarios plus a randomized transaction model.
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic reset;
  logic [1:0]    if_req, d_req, d_we, if_ack, d_ack, if_stall, d_stall, mem_en, mem_we;
  logic [AW-1:0] if_adr [2];
  logic [AW-1:0] d_adr [2];
  logic [AW-1:0] mem_adr [2];
  logic [DW-1:0] d_wdat [2];
  logic [DW-1:0] if_rdata [2];
  logic [DW-1:0] d_rdata [2];
  logic [DW-1:0] mem_wdat [2];
  logic [DW-1:0] mem_rdata [2];
  logic [1:0]    pre_we;
  logic [11:0]   pre_adr;
  logic [DW-1:0] pre_dat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? LAT0 : LAT1;
    logic [DW-1:0] store [4096] = '{default: '0};
    logic [DW-1:0] pipe [8];

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req[g]), .if_adr(if_adr[g]), .if_ack(if_ack[g]),
      .if_rdata(if_rdata[g]), .if_stall(if_stall[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_adr(d_adr[g]), .d_wdat(d_wdat[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]), .d_stall(d_stall[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_adr(mem_adr[g]),
      .mem_wdat(mem_wdat[g]), .mem_rdata(mem_rdata[g])
    );

    // Read data emerges LAT cycles after the mem_en cycle; junk otherwise.
    always @(posedge clk) begin
      if (pre_we[g]) store[pre_adr] <= pre_dat;
      else if (mem_en[g] && mem_we[g]) store[mem_adr[g][11:0]] <= mem_wdat[g];
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? store[mem_adr[g][11:0]] : 16'hDEAD;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int g, input logic [11:0] a, input logic [DW-1:0] d);
    next_cycle();
    pre_we  = 2'(1 << g);
    pre_adr = a;
    pre_dat = d;
    next_cycle();
    pre_we  = 2'b00;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({mem_en, mem_we, if_ack, d_ack} !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got=%h want=00", {mem_en, mem_we, if_ack, d_ack}); end
    for (int g = 0; g < 2; g++) begin
      n_checks++; if (mem_adr[g] !== '0 || mem_wdat[g] !== '0) begin n_fail++; $display("FAIL reset_mem_bus[%0d] adr=%h wdat=%h want=0", g, mem_adr[g], mem_wdat[g]); end
      n_checks++; if (if_rdata[g] !== '0 || d_rdata[g] !== '0) begin n_fail++; $display("FAIL reset_rdata[%0d] if=%h d=%h want=0", g, if_rdata[g], d_rdata[g]); end
    end
    next_cycle();
    reset  = 1'b0;
    if_req = 2'b00;
    d_req  = 2'b00;
    @(negedge clk);
    n_checks++; if (mem_en !== 2'b00) begin n_fail++; $display("FAIL reset_release_mem_en got=%b want=00", mem_en); end
  endtask

  task automatic test_fetch_only();
    preload(0, 12'h010, 16'hA5A5);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      if (k == 0) begin if_req[0] = 1'b1; if_adr[0] = 16'h0010; end
      if (k == 4) if_req[0] = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_en[0] !== 1'(k == 1)) begin n_fail++; $display("FAIL fetch_mem_en k=%0d got=%b want=%b", k, mem_en[0], k == 1); end
      if (k == 1) begin
        n_checks++; if (mem_we[0] !== 1'b0 || mem_adr[0] !== 16'h0010) begin n_fail++; $display("FAIL fetch_mem_cmd we=%b adr=%h want we=0 adr=0010", mem_we[0], mem_adr[0]); end
      end
      n_checks++; if (if_ack[0] !== 1'(k == 3) || d_ack[0] !== 1'b0) begin n_fail++; $display("FAIL fetch_ack k=%0d if_ack=%b d_ack=%b want if_ack=%b", k, if_ack[0], d_ack[0], k == 3); end
      n_checks++; if (if_stall[0] !== 1'(k < 3)) begin n_fail++; $display("FAIL fetch_stall k=%0d got=%b want=%b", k, if_stall[0], k < 3); end
      if (k >= 3) begin
        n_checks++; if (if_rdata[0] !== 16'hA5A5) begin n_fail++; $display("FAIL fetch_rdata k=%0d got=%h want=a5a5", k, if_rdata[0]); end
      end
    end
  endtask

  task automatic test_store_load();
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      if (k == 0) begin d_req[0] = 1'b1; d_we[0] = 1'b1; d_adr[0] = 16'h0100; d_wdat[0] = 16'h1234; end
      if (k == 3) begin d_we[0] = 1'b0; d_wdat[0] = 16'h0000; end
      if (k == 7) d_req[0] = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_en[0] !== 1'(k == 1 || k == 4)) begin n_fail++; $display("FAIL st_mem_en k=%0d got=%b", k, mem_en[0]); end
      if (k == 1) begin
        n_checks++; if (mem_we[0] !== 1'b1 || mem_adr[0] !== 16'h0100 || mem_wdat[0] !== 16'h1234) begin n_fail++; $display("FAIL st_write_cmd we=%b adr=%h wdat=%h want 1/0100/1234", mem_we[0], mem_adr[0], mem_wdat[0]); end
      end
      if (k == 4) begin
        n_checks++; if (mem_we[0] !== 1'b0 || mem_adr[0] !== 16'h0100) begin n_fail++; $display("FAIL st_read_cmd we=%b adr=%h want 0/0100", mem_we[0], mem_adr[0]); end
      end
      n_checks++; if (d_ack[0] !== 1'(k == 2 || k == 6) || if_ack[0] !== 1'b0) begin n_fail++; $display("FAIL st_ack k=%0d d_ack=%b if_ack=%b", k, d_ack[0], if_ack[0]); end
      n_checks++; if (d_stall[0] !== 1'(k < 7 && k != 2 && k != 6)) begin n_fail++; $display("FAIL st_stall k=%0d got=%b", k, d_stall[0]); end
      n_checks++; if (d_rdata[0] !== ((k >= 6) ? 16'h1234 : 16'h0000)) begin n_fail++; $display("FAIL st_d_rdata k=%0d got=%h want=%h", k, d_rdata[0], (k >= 6) ? 16'h1234 : 16'h0000); end
      n_checks++; if (if_rdata[0] !== 16'hA5A5) begin n_fail++; $display("FAIL st_if_rdata_hold k=%0d got=%h want=a5a5", k, if_rdata[0]); end
    end
  endtask

  task automatic test_contention_pair();
    int n_if, n_d, t_if, t_d;
    logic drop_f, drop_d;
    n_if = 0; n_d = 0; t_if = -1; t_d = -1; drop_f = 1'b0; drop_d = 1'b0;
    next_cycle(); reset = 1'b1;
    next_cycle(); reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      if (k == 0) begin
        if_req[0] = 1'b1; if_adr[0] = 16'h0010;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_adr[0] = 16'h0100;
      end
      if (drop_f) begin if_req[0] = 1'b0; drop_f = 1'b0; end
      if (drop_d) begin d_req[0] = 1'b0; drop_d = 1'b0; end
      @(negedge clk);
      if (if_ack[0] === 1'b1) begin
        n_if++; t_if = k; drop_f = 1'b1;
        n_checks++; if (if_rdata[0] !== 16'hA5A5) begin n_fail++; $display("FAIL pair_if_rdata got=%h want=a5a5", if_rdata[0]); end
      end
      if (d_ack[0] === 1'b1) begin
        n_d++; t_d = k; drop_d = 1'b1;
        n_checks++; if (d_rdata[0] !== 16'h1234) begin n_fail++; $display("FAIL pair_d_rdata got=%h want=1234", d_rdata[0]); end
      end
    end
    n_checks++; if (n_d != 1 || n_if != 1) begin n_fail++; $display("FAIL pair_ack_count d=%0d if=%0d want 1/1", n_d, n_if); end
    n_checks++; if (t_d != 2 + LAT0) begin n_fail++; $display("FAIL pair_d_first got_cycle=%0d want=%0d", t_d, 2 + LAT0); end
    n_checks++; if (t_if != 2 * (2 + LAT0) + 1) begin n_fail++; $display("FAIL pair_if_second got_cycle=%0d want=%0d", t_if, 2 * (2 + LAT0) + 1); end
  endtask

  task automatic test_alternation();
    int n_acks;
    int src_seq [6];
    int t_seq [6];
    n_acks = 0;
    for (int k = 0; k < 60 && n_acks < 6; k++) begin
      next_cycle();
      if (k == 0) begin
        if_req[0] = 1'b1; if_adr[0] = 16'h0010;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_adr[0] = 16'h0100;
      end
      @(negedge clk);
      n_checks++; if ((if_ack[0] & d_ack[0]) !== 1'b0) begin n_fail++; $display("FAIL alt_double_ack k=%0d if=%b d=%b", k, if_ack[0], d_ack[0]); end
      if (if_ack[0] === 1'b1 || d_ack[0] === 1'b1) begin
        src_seq[n_acks] = d_ack[0] ? 1 : 0;
        t_seq[n_acks]   = k;
        n_acks++;
      end
    end
    next_cycle();
    if_req[0] = 1'b0;
    d_req[0]  = 1'b0;
    n_checks++; if (n_acks != 6) begin n_fail++; $display("FAIL alt_ack_count got=%0d want=6", n_acks); end
    for (int i = 0; i < n_acks; i++) begin
      n_checks++; if (src_seq[i] != ((i % 2 == 0) ? 1 : 0)) begin n_fail++; $display("FAIL alt_order idx=%0d got_src=%0d want_src=%0d (1=data)", i, src_seq[i], (i % 2 == 0) ? 1 : 0); end
      n_checks++; if (t_seq[i] != (2 + LAT0) + i * (3 + LAT0)) begin n_fail++; $display("FAIL alt_timing idx=%0d got=%0d want=%0d", i, t_seq[i], (2 + LAT0) + i * (3 + LAT0)); end
    end
  endtask

  task automatic test_lat3_load();
    preload(1, 12'h200, 16'h00FF);
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      if (k == 0) begin d_req[1] = 1'b1; d_we[1] = 1'b0; d_adr[1] = 16'h0200; end
      if (k == 6) d_req[1] = 1'b0;
      @(negedge clk);
      n_checks++; if (mem_en[1] !== 1'(k == 1)) begin n_fail++; $display("FAIL lat3_mem_en k=%0d got=%b want=%b", k, mem_en[1], k == 1); end
      if (k == 1) begin
        n_checks++; if (mem_adr[1] !== 16'h0200 || mem_we[1] !== 1'b0) begin n_fail++; $display("FAIL lat3_cmd adr=%h we=%b want 0200/0", mem_adr[1], mem_we[1]); end
      end
      n_checks++; if (d_ack[1] !== 1'(k == 2 + LAT1)) begin n_fail++; $display("FAIL lat3_ack k=%0d got=%b want=%b", k, d_ack[1], k == 2 + LAT1); end
      n_checks++; if (d_stall[1] !== 1'(k < 2 + LAT1)) begin n_fail++; $display("FAIL lat3_stall k=%0d got=%b", k, d_stall[1]); end
      n_checks++; if (d_rdata[1] !== ((k >= 2 + LAT1) ? 16'h00FF : 16'h0000)) begin n_fail++; $display("FAIL lat3_rdata k=%0d got=%h", k, d_rdata[1]); end
    end
  endtask

  task automatic test_reset_in_wait();
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      if (k == 0) begin d_req[1] = 1'b1; d_we[1] = 1'b0; d_adr[1] = 16'h0200; end
      if (k == 2) reset = 1'b1;
      if (k == 3) reset = 1'b0;
      if (k == 9) d_req[1] = 1'b0;
      @(negedge clk);
      if (k == 3) begin
        n_checks++; if ({mem_en[1], mem_we[1], if_ack[1], d_ack[1]} !== 4'h0) begin n_fail++; $display("FAIL rstw_ctrl got=%b want=0000", {mem_en[1], mem_we[1], if_ack[1], d_ack[1]}); end
        n_checks++; if (mem_adr[1] !== '0 || mem_wdat[1] !== '0 || d_rdata[1] !== '0 || if_rdata[1] !== '0) begin n_fail++; $display("FAIL rstw_regs adr=%h wdat=%h d_rdata=%h if_rdata=%h want 0", mem_adr[1], mem_wdat[1], d_rdata[1], if_rdata[1]); end
      end
      n_checks++; if (mem_en[1] !== 1'(k == 1 || k == 4)) begin n_fail++; $display("FAIL rstw_mem_en k=%0d got=%b", k, mem_en[1]); end
      n_checks++; if (d_ack[1] !== 1'(k == 6 + LAT1 - 1)) begin n_fail++; $display("FAIL rstw_ack k=%0d got=%b want=%b", k, d_ack[1], k == 6 + LAT1 - 1); end
      if (k == 8) begin
        n_checks++; if (d_rdata[1] !== 16'h00FF) begin n_fail++; $display("FAIL rstw_rdata got=%h want=00ff", d_rdata[1]); end
      end
    end
  endtask

  task automatic test_random_traffic();
    logic [DW-1:0] mm [16];
    logic f_act, d_act, f_gnt, d_gnt, busy, m_last_d, m_src_d, m_we, dwe;
    logic exp_en, ack_f, ack_d, done;
    logic [DW-1:0] f_adr, dr_adr, d_wd, m_adr, m_wdat, m_rd, e_if_rd, e_d_rd;
    int m_en_k, m_ack_k;
    for (int i = 0; i < 16; i++) mm[i] = '0;
    f_act = 0; d_act = 0; f_gnt = 0; d_gnt = 0; busy = 0; m_last_d = 0;
    m_src_d = 0; m_we = 0; dwe = 0;
    f_adr = 16'h0800; dr_adr = 16'h0800; d_wd = '0; m_adr = '0; m_wdat = '0; m_rd = '0;
    e_if_rd = '0; e_d_rd = '0; m_en_k = -1; m_ack_k = -1;
    next_cycle(); reset = 1'b1;
    next_cycle(); reset = 1'b0;
    for (int k = 0; k < 400; k++) begin
      next_cycle();
      if (!f_act && $urandom_range(0, 2) == 0) f_act = 1'b1;
      if (f_act && !f_gnt && $urandom_range(0, 1) == 0) f_adr = 16'h0800 | 16'($urandom_range(0, 15));
      if (!d_act && $urandom_range(0, 2) == 0) d_act = 1'b1;
      if (d_act && !d_gnt && $urandom_range(0, 1) == 0) begin
        dwe    = 1'($urandom_range(0, 1));
        dr_adr = 16'h0800 | 16'($urandom_range(0, 15));
        d_wd   = 16'($urandom);
      end
      if_req[0] = f_act; if_adr[0] = f_adr;
      d_req[0] = d_act; d_we[0] = dwe; d_adr[0] = dr_adr; d_wdat[0] = d_wd;
      @(negedge clk);
      ack_f = 0; ack_d = 0; exp_en = 0; done = 0;
      if (busy) begin
        exp_en = (k == m_en_k);
        if (k == m_ack_k) begin
          done = 1;
          if (m_src_d) begin ack_d = 1; if (!m_we) e_d_rd = m_rd; end
          else begin ack_f = 1; e_if_rd = m_rd; end
        end
      end else if (f_act || d_act) begin
        m_src_d  = d_act && (!f_act || !m_last_d);
        m_last_d = m_src_d;
        m_we     = m_src_d && dwe;
        m_adr    = m_src_d ? dr_adr : f_adr;
        m_wdat   = d_wd;
        m_rd     = mm[m_adr[3:0]];
        if (m_we) mm[m_adr[3:0]] = d_wd;
        m_en_k   = k + 1;
        m_ack_k  = k + 2 + (m_we ? 0 : LAT0);
        busy     = 1;
        if (m_src_d) d_gnt = 1; else f_gnt = 1;
      end
      n_checks++; if (if_ack[0] !== ack_f) begin n_fail++; $display("FAIL rnd_if_ack k=%0d got=%b want=%b", k, if_ack[0], ack_f); end
      n_checks++; if (d_ack[0] !== ack_d) begin n_fail++; $display("FAIL rnd_d_ack k=%0d got=%b want=%b", k, d_ack[0], ack_d); end
      n_checks++; if (mem_en[0] !== exp_en) begin n_fail++; $display("FAIL rnd_mem_en k=%0d got=%b want=%b", k, mem_en[0], exp_en); end
      if (exp_en) begin
        n_checks++; if (mem_adr[0] !== m_adr || mem_we[0] !== m_we) begin n_fail++; $display("FAIL rnd_mem_cmd k=%0d adr=%h we=%b want adr=%h we=%b", k, mem_adr[0], mem_we[0], m_adr, m_we); end
        if (m_we) begin
          n_checks++; if (mem_wdat[0] !== m_wdat) begin n_fail++; $display("FAIL rnd_mem_wdat k=%0d got=%h want=%h", k, mem_wdat[0], m_wdat); end
        end
      end
      n_checks++; if (if_rdata[0] !== e_if_rd) begin n_fail++; $display("FAIL rnd_if_rdata k=%0d got=%h want=%h", k, if_rdata[0], e_if_rd); end
      n_checks++; if (d_rdata[0] !== e_d_rd) begin n_fail++; $display("FAIL rnd_d_rdata k=%0d got=%h want=%h", k, d_rdata[0], e_d_rd); end
      n_checks++; if (if_stall[0] !== (f_act & ~ack_f) || d_stall[0] !== (d_act & ~ack_d)) begin n_fail++; $display("FAIL rnd_stall k=%0d if=%b d=%b want if=%b d=%b", k, if_stall[0], d_stall[0], f_act & ~ack_f, d_act & ~ack_d); end
      if (ack_f) begin f_act = 0; f_gnt = 0; end
      if (ack_d) begin d_act = 0; d_gnt = 0; end
      if (done) busy = 0;
    end
    next_cycle();
    if_req[0] = 1'b0;
    d_req[0]  = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    if_req  = 2'b11;
    d_req   = 2'b11;
    d_we    = 2'b11;
    pre_we  = 2'b00;
    pre_adr = '0;
    pre_dat = '0;
    for (int g = 0; g < 2; g++) begin
      if_adr[g] = 16'h0333;
      d_adr[g]  = 16'h0444;
      d_wdat[g] = 16'hBEEF;
    end
    test_reset();
    d_we = 2'b00;
    test_fetch_only();
    test_store_load();
    test_contention_pair();
    test_alternation();
    test_lat3_load();
    test_reset_in_wait();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
